// File: rtl/regfile_dump_reader.sv
// Read-side sequencer that walks a register range through both read ports of the
// 32 x 64-bit register file and streams each value with its index over valid/ready.
module regfile_dump_reader #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic [ADDR_W-1:0] RS1,
    output logic [ADDR_W-1:0] RS2,
    input  logic [DATA_W-1:0] ReadData1,
    input  logic [DATA_W-1:0] ReadData2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] READ   = 3'd1;
    localparam logic [2:0] SEND_A = 3'd2;
    localparam logic [2:0] SEND_B = 3'd3;
    localparam logic [2:0] FIN    = 3'd4;

    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
        if (a == ADDR_W'(NUM_REGS - 1)) begin
            wrap_inc = '0;
        end else begin
            wrap_inc = a + ADDR_W'(1);
        end
    endfunction

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [DATA_W-1:0] hold_a_q, hold_a_d;
    logic [DATA_W-1:0] hold_b_q, hold_b_d;
    logic [ADDR_W-1:0] rs1_q, rs1_d;
    logic [ADDR_W-1:0] rs2_q, rs2_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              hs_s;
    logic [ADDR_W-1:0] ptr_plus1_s;

    assign hs_s        = out_valid_q & out_ready;
    assign ptr_plus1_s = wrap_inc(ptr_q);

    // Next-state, pointer and holding-register update.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        last_d   = last_q;
        hold_a_d = hold_a_q;
        hold_b_d = hold_b_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (first_reg > last_reg) begin
                        state_d = FIN;
                    end else begin
                        ptr_d   = first_reg;
                        last_d  = last_reg;
                        state_d = READ;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                hold_a_d = ReadData1;
                hold_b_d = ReadData2;
                state_d  = SEND_A;
            end
            SEND_A: begin
                if (hs_s) begin
                    state_d = (ptr_q == last_q) ? FIN : SEND_B;
                end else begin
                    state_d = SEND_A;
                end
            end
            SEND_B: begin
                if (hs_s) begin
                    if (ptr_plus1_s == last_q) begin
                        state_d = FIN;
                    end else begin
                        ptr_d   = wrap_inc(ptr_plus1_s);
                        state_d = READ;
                    end
                end else begin
                    state_d = SEND_B;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are precomputed from next state so every port comes straight off a flop;
    // read addresses are loaded on entry to READ and otherwise hold.
    always_comb begin
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        out_valid_d = (state_d == SEND_A) || (state_d == SEND_B);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == FIN);
        if (state_d == READ) begin
            rs1_d = ptr_d;
            rs2_d = wrap_inc(ptr_d);
        end else begin
            rs1_d = rs1_q;
            rs2_d = rs2_q;
        end
        case (state_d)
            SEND_A: begin
                out_addr_d = ptr_d;
                out_data_d = hold_a_d;
            end
            SEND_B: begin
                out_addr_d = wrap_inc(ptr_d);
                out_data_d = hold_b_d;
            end
            default: begin
                out_addr_d = '0;
                out_data_d = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            last_q      <= '0;
            hold_a_q    <= '0;
            hold_b_q    <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            last_q      <= last_d;
            hold_a_q    <= hold_a_d;
            hold_b_q    <= hold_b_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign RS1       = rs1_q;
    assign RS2       = rs2_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
